// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the multicycle CPU datapath.
//   - CPU_WIDTH        : default datapath width.
//   - alu_src_a_e      : encodings of the ALUSrcA control field.
//   - is_rsv_src_a()   : true when the select is the reserved code.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_WIDTH = 32;

    typedef enum logic [1:0] {
        ALU_SRC_A_PC  = 2'd0,
        ALU_SRC_A_A   = 2'd1,
        ALU_SRC_A_MDR = 2'd2,
        ALU_SRC_A_RSV = 2'd3
    } alu_src_a_e;

    function automatic logic is_rsv_src_a(input logic [1:0] sel);
        return (sel == ALU_SRC_A_RSV);
    endfunction

endpackage : cpu_pkg

// File: rtl/mux3_w.sv
// -----------------------------------------------------------------------------
// mux3_w
//   Generic WIDTH-bit 3:1 multiplexer with a default value for the unused
//   fourth code. Purely combinational.
//   Ports:
//     sel  in  2      0 -> in0, 1 -> in1, 2 -> in2, anything else -> DEF_VAL
//     in0  in  WIDTH
//     in1  in  WIDTH
//     in2  in  WIDTH
//     y    out WIDTH  selected value
// -----------------------------------------------------------------------------
module mux3_w #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DEF_VAL = '0
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] y
);

    // An X/Z select matches none of the listed items in simulation and falls
    // to the default, so an unknown select never propagates a data input.
    always_comb begin
        y = DEF_VAL;
        case (sel)
            2'd0:    y = in0;
            2'd1:    y = in1;
            2'd2:    y = in2;
            default: y = DEF_VAL;
        endcase
    end

endmodule : mux3_w

// File: rtl/alu_a_mux.sv
// -----------------------------------------------------------------------------
// alu_a_mux
//   Operand-A source selector for the multicycle CPU ALU. The combinational
//   output feeds the ALU in the same cycle; a registered copy and a sticky
//   reserved-select flag are kept for debug/trace.
//   Ports:
//     clk         in   1      rising-edge clock
//     rst_n       in   1      asynchronous active-low reset
//     ALUSrcA     in   2      0=PC, 1=A, 2=MDR, 3=reserved
//     PC          in   WIDTH  program counter
//     A           in   WIDTH  register-file read latch A
//     MDR         in   WIDTH  memory data register
//     Data_out    out  WIDTH  selected operand (combinational, unaffected by reset)
//     Data_out_q  out  WIDTH  Data_out captured on clk
//     sel_err     out  1      set when ALUSrcA==3 at a clock edge, cleared only by reset
// -----------------------------------------------------------------------------
module alu_a_mux
    import cpu_pkg::*;
#(
    parameter int               WIDTH   = CPU_WIDTH,
    parameter logic [WIDTH-1:0] ILL_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ALUSrcA,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] MDR,
    output logic [WIDTH-1:0] Data_out,
    output logic [WIDTH-1:0] Data_out_q,
    output logic             sel_err
);

    logic [WIDTH-1:0] dout_d, dout_q;
    logic             sel_err_d, sel_err_q;

    mux3_w #(
        .WIDTH   (WIDTH),
        .DEF_VAL (ILL_VAL)
    ) u_mux (
        .sel (ALUSrcA),
        .in0 (PC),
        .in1 (A),
        .in2 (MDR),
        .y   (Data_out)
    );

    always_comb begin
        dout_d    = Data_out;
        sel_err_d = sel_err_q | is_rsv_src_a(ALUSrcA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign Data_out_q = dout_q;
    assign sel_err    = sel_err_q;

endmodule : alu_a_mux

// File: tb/tb_alu_a_mux.sv
module tb_alu_a_mux;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    ALUSrcA;
    logic [W-1:0]  PC, A, MDR;
    logic [W-1:0]  Data_out, Data_out_q;
    logic          sel_err;

    int total = 0;
    int bad   = 0;

    // kind: 0 = Data_out, 1 = Data_out_q, 2 = sel_err
    typedef struct {
        string        name;
        int           kind;
        logic [W-1:0] exp;
    } chk_t;

    chk_t q[$];
    event ev;

    alu_a_mux #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALUSrcA    (ALUSrcA),
        .PC         (PC),
        .A          (A),
        .MDR        (MDR),
        .Data_out   (Data_out),
        .Data_out_q (Data_out_q),
        .sel_err    (sel_err)
    );

    always #5 clk = ~clk;

    // Monitor: drains the scoreboard whenever stimulus announces settled outputs.
    initial begin
        chk_t         it;
        logic [W-1:0] act;
        forever begin
            @(ev);
            while (q.size() > 0) begin
                it = q.pop_front();
                case (it.kind)
                    0:       act = Data_out;
                    1:       act = Data_out_q;
                    default: act = {{(W-1){1'b0}}, sel_err};
                endcase
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic void push(input string name, input int kind, input logic [W-1:0] exp);
        chk_t c;
        c.name = name; c.kind = kind; c.exp = exp;
        q.push_back(c);
    endfunction

    task automatic fire();
        ->ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [W-1:0] ref_mux(input logic [1:0] s, input logic [W-1:0] p,
                                             input logic [W-1:0] a, input logic [W-1:0] m);
        if (s == 2'd0) return p;
        if (s == 2'd1) return a;
        if (s == 2'd2) return m;
        return '0;
    endfunction

    initial begin
        logic [W-1:0] prev_do;
        logic         err_m;
        logic [1:0]   sels[3];
        logic [W-1:0] exps[3];

        // 1. asynchronous reset without any clock edge
        rst_n = 1'b0; ALUSrcA = 2'd0; PC = '0; A = '0; MDR = '0;
        #2;
        push("rst_dq", 1, 32'h0);
        push("rst_err", 2, 32'h0);
        fire();
        PC = 32'd5;
        #1;
        push("pc_in_reset", 0, 32'd5);
        fire();
        rst_n = 1'b1;
        tick();
        push("dq_first", 1, 32'd5);
        push("err_first", 2, 32'h0);
        fire();

        // 2. basic selection
        ALUSrcA = 2'd1; PC = '0; A = 32'd5; MDR = '0; #1;
        push("sel_a", 0, 32'd5); fire();
        ALUSrcA = 2'd2; A = '0; MDR = 32'd5; #1;
        push("sel_mdr", 0, 32'd5); fire();
        PC = 32'h11; A = 32'h22; MDR = 32'h33;
        sels[0] = 2'd0; sels[1] = 2'd1; sels[2] = 2'd2;
        exps[0] = 32'h11; exps[1] = 32'h22; exps[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            ALUSrcA = sels[i]; #1;
            push("cycle_sel", 0, exps[i]); fire();
        end

        // 3. reserved select sets sticky flag
        ALUSrcA = 2'd3; #1;
        push("rsv_do", 0, 32'h0); fire();
        tick();
        push("rsv_err", 2, 32'h1);
        push("rsv_dq", 1, 32'h0);
        fire();
        ALUSrcA = 2'd0;
        tick();
        push("err_sticky", 2, 32'h1);
        push("dq_after_rsv", 1, 32'h11);
        fire();

        // 4. mid-operation reset pulse between edges
        ALUSrcA = 2'd1;
        tick();
        push("dq_pre_rst", 1, 32'h22);
        push("err_pre_rst", 2, 32'h1);
        fire();
        rst_n = 1'b0; #1;
        push("rst_mid_dq", 1, 32'h0);
        push("rst_mid_err", 2, 32'h0);
        push("rst_mid_do", 0, 32'h22);
        fire();
        ALUSrcA = 2'd2; #1;
        push("rst_track_do", 0, 32'h33); fire();
        tick();
        push("rst_hold_dq", 1, 32'h0);
        push("rst_hold_err", 2, 32'h0);
        fire();
        rst_n = 1'b1;
        tick();
        push("resume_dq", 1, 32'h33);
        push("resume_err", 2, 32'h0);
        fire();

        // 5. unselected input changes; walking ones on every input
        ALUSrcA = 2'd1; PC = 32'hDEAD_BEEF; #1;
        push("pc_ignored", 0, 32'h22); fire();
        PC = '0; A = '0; MDR = '0;
        for (int i = 0; i < W; i++) begin
            ALUSrcA = 2'd0; PC = 32'h1 << i; A = ~(32'h1 << i); MDR = ~(32'h1 << i); #1;
            push("walk_pc", 0, 32'h1 << i); fire();
            ALUSrcA = 2'd1; A = 32'h1 << i; PC = ~(32'h1 << i); #1;
            push("walk_a", 0, 32'h1 << i); fire();
            ALUSrcA = 2'd2; MDR = 32'h1 << i; A = ~(32'h1 << i); #1;
            push("walk_mdr", 0, 32'h1 << i); fire();
        end

        // 6. randomized run against the reference model
        rst_n = 1'b0; #1; rst_n = 1'b1;
        err_m = 1'b0;
        ALUSrcA = 2'd0; PC = '0; #1;
        prev_do = '0;
        for (int c = 0; c < 1000; c++) begin
            ALUSrcA = (($urandom_range(0, 15)) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            PC = $urandom; A = $urandom; MDR = $urandom;
            #1;
            prev_do = ref_mux(ALUSrcA, PC, A, MDR);
            push("rnd_do", 0, prev_do);
            fire();
            if (ALUSrcA == 2'd3) err_m = 1'b1;
            tick();
            push("rnd_dq", 1, prev_do);
            push("rnd_err", 2, {{(W-1){1'b0}}, err_m});
            fire();
        end

        #2;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d checks left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_a_mux
